// File: rtl/alu_issue_if.sv
// Fetch-side and execute-side signal bundle for the alu_issue decode/issue stage.
interface alu_issue_if #(
  parameter int XLEN    = 64,
  parameter int ALUOP_W = 2
);
  logic               inst_valid;
  logic               inst_ready;
  logic [31:0]        inst;
  logic [XLEN-1:0]    pc;
  logic [4:0]         rs1_addr;
  logic [4:0]         rs2_addr;
  logic [XLEN-1:0]    rs1_data;
  logic [XLEN-1:0]    rs2_data;
  logic               ex_valid;
  logic               ex_ready;
  logic [ALUOP_W-1:0] alu_op;
  logic [XLEN-1:0]    operator_1;
  logic [XLEN-1:0]    operator_2;
  logic [4:0]         rd;
  logic               rd_wen;
  logic               illegal;

  // The stage's own view.
  modport slave (
    input  inst_valid, inst, pc, rs1_data, rs2_data, ex_ready,
    output inst_ready, rs1_addr, rs2_addr, ex_valid, alu_op,
           operator_1, operator_2, rd, rd_wen, illegal
  );

  // The surrounding fetch, register-file and execute logic.
  modport master (
    output inst_valid, inst, pc, rs1_data, rs2_data, ex_ready,
    input  inst_ready, rs1_addr, rs2_addr, ex_valid, alu_op,
           operator_1, operator_2, rd, rd_wen, illegal
  );
endinterface

// File: rtl/alu_issue.sv
// RV64I ALU-subset decode and issue register. Define ALU_ISSUE_SKID_EN to add a
// one-entry skid so inst_ready is registered instead of combinational.
module alu_issue #(
  parameter int XLEN    = 64,
  parameter int ALUOP_W = 2
) (
  input  logic        clk,
  input  logic        rst,
  alu_issue_if.slave  io
);
  localparam logic [ALUOP_W-1:0] OP_ADD = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] OP_SUB = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] OP_LT  = ALUOP_W'(2);

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef struct packed {
    logic [ALUOP_W-1:0] alu_op;
    logic [XLEN-1:0]    op1;
    logic [XLEN-1:0]    op2;
    logic [4:0]         rd;
    logic               rd_wen;
    logic               illegal;
  } issue_t;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_u;
  logic            legal;
  issue_t          dec;

  assign opcode      = io.inst[6:0];
  assign funct3      = io.inst[14:12];
  assign funct7      = io.inst[31:25];
  assign io.rs1_addr = io.inst[19:15];
  assign io.rs2_addr = io.inst[24:20];
  assign imm_i       = {{(XLEN-12){io.inst[31]}}, io.inst[31:20]};
  assign imm_u       = {{(XLEN-32){io.inst[31]}}, io.inst[31:12], 12'b0};

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    dec   = '0;
    legal = 1'b1;
    case (opcode)
      OPC_OP_IMM: begin
        dec.op1 = io.rs1_data;
        dec.op2 = imm_i;
        if (funct3 == 3'b000)      dec.alu_op = OP_ADD;
        else if (funct3 == 3'b010) dec.alu_op = OP_LT;
        else                       legal = 1'b0;
      end
      OPC_OP: begin
        dec.op1 = io.rs1_data;
        dec.op2 = io.rs2_data;
        if (funct3 == 3'b000 && funct7 == 7'b0000000)      dec.alu_op = OP_ADD;
        else if (funct3 == 3'b000 && funct7 == 7'b0100000) dec.alu_op = OP_SUB;
        else if (funct3 == 3'b010 && funct7 == 7'b0000000) dec.alu_op = OP_LT;
        else                                               legal = 1'b0;
      end
      OPC_LUI: begin
        dec.op2 = imm_u;
      end
      OPC_AUIPC: begin
        dec.op1 = io.pc;
        dec.op2 = imm_u;
      end
      default: legal = 1'b0;
    endcase

    // Undecodable words still issue, as a harmless add of zeros flagged illegal.
    if (legal) begin
      dec.rd     = io.inst[11:7];
      dec.rd_wen = |io.inst[11:7];
    end else begin
      dec         = '0;
      dec.illegal = 1'b1;
    end
  end

  issue_t issue_q;
  logic   ex_valid_q;
  logic   accept;
  logic   take;

  assign accept = io.inst_valid && io.inst_ready;
  assign take   = ex_valid_q && io.ex_ready;

`ifdef ALU_ISSUE_SKID_EN
  issue_t skid_q;
  logic   skid_full;

  assign io.inst_ready = !skid_full;

  // The skid only fills while the issue register is occupied and stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_q    <= '0;
      ex_valid_q <= 1'b0;
      skid_q     <= '0;
      skid_full  <= 1'b0;
    end else if (!ex_valid_q || take) begin
      if (skid_full) begin
        issue_q    <= skid_q;
        ex_valid_q <= 1'b1;
        skid_full  <= 1'b0;
      end else if (accept) begin
        issue_q    <= dec;
        ex_valid_q <= 1'b1;
      end else begin
        ex_valid_q <= 1'b0;
      end
    end else if (accept) begin
      skid_q    <= dec;
      skid_full <= 1'b1;
    end
  end
`else
  assign io.inst_ready = !ex_valid_q || io.ex_ready;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_q    <= '0;
      ex_valid_q <= 1'b0;
    end else if (accept) begin
      issue_q    <= dec;
      ex_valid_q <= 1'b1;
    end else if (take) begin
      ex_valid_q <= 1'b0;
    end
  end
`endif

  assign io.ex_valid   = ex_valid_q;
  assign io.alu_op     = issue_q.alu_op;
  assign io.operator_1 = issue_q.op1;
  assign io.operator_2 = issue_q.op2;
  assign io.rd         = issue_q.rd;
  assign io.rd_wen     = issue_q.rd_wen;
  assign io.illegal    = issue_q.illegal;
endmodule

// File: tb/tb_alu_issue.sv
// Scoreboard bench for alu_issue: random and directed instructions against an ISA-level model.
module tb_alu_issue;
  typedef struct {
    logic [1:0]  alu_op;
    logic [63:0] op1;
    logic [63:0] op2;
    logic [4:0]  rd;
    logic        rd_wen;
    logic        illegal;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [63:0] regs [32];
  exp_t q [$];
  int   total  = 0;
  int   passed = 0;
  int   ready_mode = 0;  // 0: ex_ready high, 1: random, 2: low

  alu_issue_if #(.XLEN(64), .ALUOP_W(2)) bus ();

  alu_issue #(.XLEN(64), .ALUOP_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  always #5 clk = ~clk;

  assign bus.rs1_data = regs[bus.rs1_addr];
  assign bus.rs2_data = regs[bus.rs2_addr];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference: instruction semantics computed directly from the ISA fields.
  function automatic exp_t model(input logic [31:0] w, input logic [63:0] p);
    exp_t   e;
    logic [6:0] opc = w[6:0];
    logic [2:0] f3 = w[14:12];
    logic [6:0] f7 = w[31:25];
    longint imm_i = longint'($signed(w[31:20]));
    longint imm_u = longint'($signed({w[31:12], 12'h000}));
    bit ok = 1;
    e = '{alu_op: 2'd0, op1: 64'd0, op2: 64'd0, rd: 5'd0, rd_wen: 1'b0, illegal: 1'b0};
    if (opc == 7'h13 && (f3 == 3'd0 || f3 == 3'd2)) begin
      e.alu_op = (f3 == 3'd0) ? 2'd0 : 2'd2;
      e.op1 = regs[w[19:15]];
      e.op2 = 64'(imm_i);
    end else if (opc == 7'h33 && f3 == 3'd0 && (f7 == 7'h00 || f7 == 7'h20)) begin
      e.alu_op = (f7 == 7'h00) ? 2'd0 : 2'd1;
      e.op1 = regs[w[19:15]];
      e.op2 = regs[w[24:20]];
    end else if (opc == 7'h33 && f3 == 3'd2 && f7 == 7'h00) begin
      e.alu_op = 2'd2;
      e.op1 = regs[w[19:15]];
      e.op2 = regs[w[24:20]];
    end else if (opc == 7'h37) begin
      e.op2 = 64'(imm_u);
    end else if (opc == 7'h17) begin
      e.op1 = p;
      e.op2 = 64'(imm_u);
    end else begin
      ok = 0;
    end
    if (ok) begin
      e.rd = w[11:7];
      e.rd_wen = (w[11:7] != 5'd0);
    end else begin
      e.illegal = 1'b1;
    end
    return e;
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [4:0] rd = 5'($urandom);
    logic [4:0] r1 = 5'($urandom);
    logic [4:0] r2 = 5'($urandom);
    logic [11:0] im = 12'($urandom);
    logic [19:0] iu = 20'($urandom);
    case ($urandom_range(0, 9))
      0: return {im, r1, 3'd0, rd, 7'h13};
      1: return {im, r1, 3'd2, rd, 7'h13};
      2: return {7'h00, r2, r1, 3'd0, rd, 7'h33};
      3: return {7'h20, r2, r1, 3'd0, rd, 7'h33};
      4: return {7'h00, r2, r1, 3'd2, rd, 7'h33};
      5: return {iu, rd, 7'h37};
      6: return {iu, rd, 7'h17};
      7: return 32'($urandom);
      8: return {im, r1, 3'($urandom), rd, 7'h13};
      default: return {7'($urandom), r2, r1, 3'($urandom), rd, 7'h33};
    endcase
  endfunction

  // Present one instruction and hold it until the stage accepts it.
  task automatic send(input logic [31:0] w, input logic [63:0] p);
    bit done = 0;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk);
      bus.inst_valid = 1'b1;
      bus.inst = w;
      bus.pc = p;
      #3;
      if (bus.inst_ready) begin
        q.push_back(model(w, p));
        @(posedge clk);
        done = 1;
      end
    end
    if (!done) check("accept_timeout", bus.inst_ready, 1);
  endtask

  task automatic idle();
    @(negedge clk);
    bus.inst_valid = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 1000 && q.size() != 0; n++) begin
      @(negedge clk);
      #4;
    end
    check("drain", q.size(), 0);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      case (ready_mode)
        0: bus.ex_ready = 1'b1;
        1: bus.ex_ready = 1'($urandom_range(0, 1));
        default: bus.ex_ready = 1'b0;
      endcase
    end
  end

  // Monitor: compares the issue slot with the scoreboard front every cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst) begin
        check("ex_valid", bus.ex_valid, q.size() != 0);
`ifdef ALU_ISSUE_SKID_EN
        check("inst_ready", bus.inst_ready, q.size() < 2);
`else
        check("inst_ready", bus.inst_ready, q.size() == 0 || bus.ex_ready);
`endif
        if (bus.ex_valid && q.size() != 0) begin
          e = q[0];
          check("alu_op", bus.alu_op, e.alu_op);
          check("operator_1", bus.operator_1, e.op1);
          check("operator_2", bus.operator_2, e.op2);
          check("rd", bus.rd, e.rd);
          check("rd_wen", bus.rd_wen, e.rd_wen);
          check("illegal", bus.illegal, e.illegal);
          if (bus.ex_ready) void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    bus.inst_valid = 1'b0;
    bus.inst = 32'd0;
    bus.pc = 64'd0;
    bus.ex_ready = 1'b1;
    for (int i = 0; i < 32; i++) regs[i] = {32'($urandom), 32'($urandom)};
    regs[0] = 64'd0;
    regs[1] = 64'd7;
    regs[2] = 64'd9;

    #1;
    check("rst_ex_valid", bus.ex_valid, 0);
    check("rst_alu_op", bus.alu_op, 0);
    check("rst_operator_1", bus.operator_1, 0);
    check("rst_operator_2", bus.operator_2, 0);
    check("rst_rd", bus.rd, 0);
    check("rst_rd_wen", bus.rd_wen, 0);
    check("rst_illegal", bus.illegal, 0);
    check("rst_inst_ready", bus.inst_ready, 1);
    #11 rst = 1'b0;

    send(32'h00500093, 64'h1000);  // ADDI x1,x0,5
    send(32'hFFF00093, 64'h1004);  // ADDI x1,x0,-1
    send(32'h800002B7, 64'h1008);  // LUI x5,0x80000
    send(32'h402081B3, 64'h100C);  // SUB x3,x1,x2
    send(32'h0020A1B3, 64'h1010);  // SLT x3,x1,x2
    send(32'h00208033, 64'h1014);  // ADD x0,x1,x2
    send(32'hFFFFFFFF, 64'h1018);  // illegal
    send(32'h12345297, 64'h8000_0000_0000_101C);  // AUIPC x5
    idle();
    drain();

    // Stall with three back-to-back instructions.
    ready_mode = 2;
    fork
      begin
        repeat (6) @(negedge clk);
        ready_mode = 0;
      end
      begin
        send(32'h00500093, 64'h2000);
        send(32'h002081B3, 64'h2004);
        send(32'h402081B3, 64'h2008);
      end
    join
    idle();
    drain();

    ready_mode = 1;
    for (int i = 1; i < 32; i++) regs[i] = {32'($urandom), 32'($urandom)};
    repeat (300) begin
      if ($urandom_range(0, 3) == 0) idle();
      send(rand_inst(), {32'($urandom), 30'($urandom), 2'b00});
    end
    idle();
    ready_mode = 0;
    drain();

    // Reset while an instruction is held stalled.
    ready_mode = 2;
    send(32'h00700093, 64'h3000);
    idle();
    repeat (2) @(negedge clk);
    #1;
    check("pre_rst_ex_valid", bus.ex_valid, 1);
    rst = 1'b1;
    q.delete();
    #1;
    check("async_rst_ex_valid", bus.ex_valid, 0);
    check("async_rst_inst_ready", bus.inst_ready, 1);
    check("async_rst_operator_2", bus.operator_2, 0);
    @(negedge clk);
    #1 rst = 1'b0;
    ready_mode = 0;
    repeat (4) @(negedge clk);
    #4;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/alu_issue.md
# alu_issue

Decode-and-issue stage that feeds the ALU. It accepts one 32-bit RV64I instruction per handshake from the fetch side and reads its source registers through combinational register-file ports. It decodes the ALU-class subset into `alu_op`, `operator_1` and `operator_2`, then holds them in a valid/ready output register until the execute stage takes them. It sits between the IFU and the ALU/EXU and owns all operand selection and immediate sign-extension.

## Interface
Parameters:
- `XLEN`, 64, datapath and operand width.
- `ALUOP_W`, 2, ALU opcode width. Encodings: add = 0, sub = 1, signed less-than = 2.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `inst_valid`  in  1  fetch offers `inst`/`pc`.
- `inst_ready`  out  1  stage can accept an instruction.
- `inst`  in  32  instruction word.
- `pc`  in  XLEN  address of `inst`.
- `rs1_addr`, `rs2_addr`  out  5  combinational from `inst[19:15]` and `inst[24:20]`.
- `rs1_data`, `rs2_data`  in  XLEN  register-file read data, same cycle.
- `ex_valid`  out  1  issue register holds an instruction.
- `ex_ready`  in  1  execute stage accepts.
- `alu_op`  out  ALUOP_W  ALU operation.
- `operator_1`, `operator_2`  out  XLEN  ALU operands.
- `rd`  out  5  destination register.
- `rd_wen`  out  1  write-back enable; 0 when `rd` = 0.
- `illegal`  out  1  issued slot carries an undecodable instruction.

## Operation
Decode per opcode:
- ADDI (0010011, f3 000): add, rs1 / imm_I.
- SLTI (f3 010): lt, rs1 / imm_I.
- ADD (0110011, f3 000, f7 0000000): add, rs1 / rs2.
- SUB (f7 0100000): sub, rs1 / rs2.
- SLT (f3 010, f7 0): lt, rs1 / rs2.
- LUI (0110111): add, 0 / imm_U.
- AUIPC (0010111): add, pc / imm_U.
- imm_I = sext(`inst[31:20]`).
- imm_U = sext({`inst[31:12]`, 12'b0}), sign-extended from bit 31 to XLEN.

Any other encoding:
- Issued with `illegal`=1, `alu_op`=add, both operands 0, `rd_wen`=0.
- Does not stall the pipe; trap handling belongs downstream.

Handshake:
- Accept when `inst_valid && inst_ready`.
- Transfer out when `ex_valid && ex_ready`.
- Without skid, `inst_ready = !ex_valid || ex_ready`.
- Accept and transfer out in the same cycle replaces the issue register with the new instruction; no bubble.
- Outputs are stable while `ex_valid && !ex_ready`.
- `rs1_data`/`rs2_data` are sampled only on the accept edge.

## Timing
- Latency: 1 cycle from accept edge to `ex_valid`=1 with decoded outputs.
- Throughput: 1 instruction per cycle when `ex_ready` is held high.
- Reset values: `ex_valid`=0, `alu_op`=0, `operator_1`=0, `operator_2`=0, `rd`=0, `rd_wen`=0, `illegal`=0.
- `inst_ready`=1 during and after reset (no skid).
- Reset asserted mid-handshake discards the held instruction immediately (asynchronous); no transfer completes on that edge.
- `inst_valid` while `inst_ready`=0: no state change; fetch must hold its request.

## Configuration
- `ALU_ISSUE_SKID_EN` defined:
  - Adds a second holding entry (skid).
  - `inst_ready` becomes a register output equal to `!skid_full`, with no combinational path from `ex_ready`.
  - On accept while the issue register is stalled, the decoded instruction goes to the skid; `inst_ready` drops the next cycle.
  - On the next transfer out, the skid moves into the issue register and `inst_ready` rises the following cycle.
  - Order is strictly FIFO.
  - Reset clears the skid.
- `ALU_ISSUE_SKID_EN` undefined: single register, combinational `inst_ready` as in Operation.

## Test plan
- ADDI x1,x0,5 (0x00500093), rs1_data=0, `ex_ready`=1 → next cycle: `ex_valid`=1, `alu_op`=0, operands 0 / 5, `rd`=1, `rd_wen`=1.
- ADDI x1,x0,-1 (0xFFF00093) → `operator_2`=0xFFFFFFFFFFFFFFFF.
- LUI x5,0x80000 (0x800002B7) → `operator_2`=0xFFFFFFFF80000000.
- SUB x3,x1,x2 (0x402081B3), rs1=7, rs2=9 → `alu_op`=1, operands 7 / 9.
- SLT x3,x1,x2 (0x0020A1B3) → `alu_op`=2.
- ADD with rd=0 (0x00208033) → `rd_wen`=0.
- Back-to-back ADDI/ADD/SUB with `ex_ready` low for 3 cycles:
  - Outputs hold the ADDI values.
  - Without skid: `inst_ready`=0 during the stall.
  - With skid: exactly one extra instruction is accepted.
  - After release, all three issue in order with no loss or duplication.
- Word 0xFFFFFFFF → `illegal`=1, `rd_wen`=0, operands 0.
- `rst` pulsed while `ex_valid`=1 and `ex_ready`=0 → `ex_valid`=0 asynchronously and the held instruction is never seen downstream.
